// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, instruction-memory address drive,
// redirect handling and the IF/ID pipeline register, with a BOOT/RUN/FAULT FSM.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fetch_fault
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_WORDS * 4 - 4);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [31:0] pc_plus4;

    // Misaligned or past the last word of instruction memory.
    function automatic logic is_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
    endfunction

    // Memory read is combinational, so the address comes straight off the PC flop.
    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_valid    = ifid_valid_q;
    assign fetch_fault   = fetch_fault_q;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state, next-PC and next IF/ID contents.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_valid_d    = ifid_valid_q;

        case (state_q)
            S_BOOT: begin
                ifid_valid_d    = 1'b0;
                ifid_instr_d    = NOP_INSTR;
                ifid_pc_d       = pc_q;
                ifid_pc_plus4_d = pc_plus4;
                state_d         = is_bad(pc_q) ? S_FAULT : S_RUN;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    pc_d            = redirect_target;
                    ifid_valid_d    = 1'b0;
                    ifid_instr_d    = NOP_INSTR;
                    ifid_pc_d       = pc_q;
                    ifid_pc_plus4_d = pc_plus4;
                    if (is_bad(redirect_target)) begin
                        state_d = S_FAULT;
                    end
                end else if (stall) begin
                    // PC holds; flush still turns the held IF/ID entry into a bubble.
                    if (flush) begin
                        ifid_valid_d    = 1'b0;
                        ifid_instr_d    = NOP_INSTR;
                        ifid_pc_d       = pc_q;
                        ifid_pc_plus4_d = pc_plus4;
                    end
                end else begin
                    pc_d = pc_plus4;
                    if (is_bad(pc_plus4)) begin
                        state_d = S_FAULT;
                    end
                    ifid_pc_d       = pc_q;
                    ifid_pc_plus4_d = pc_plus4;
                    if (flush) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NOP_INSTR;
                    end else begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_instr;
                    end
                end
            end
            S_FAULT: begin
                ifid_valid_d    = 1'b0;
                ifid_instr_d    = NOP_INSTR;
                ifid_pc_d       = pc_q;
                ifid_pc_plus4_d = pc_plus4;
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = is_bad(redirect_target) ? S_FAULT : S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        fetch_fault_d = (state_d == S_FAULT);
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_BOOT;
            pc_q            <= RESET_PC;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_q       <= 32'd0;
            ifid_pc_plus4_q <= 32'd0;
            ifid_valid_q    <= 1'b0;
            fetch_fault_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_fault_q   <= fetch_fault_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: directed stimulus pushes expected fetches,
// a negedge monitor pops them whenever a fresh valid IF/ID entry appears.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        fetch_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic held   = 1'b0;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(1024),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_valid     (ifid_valid),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory model: word i holds 32'h1000_0000 + i.
    assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h1000_0000 + {2'b00, pc[31:2]};
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Remember whether the last edge froze IF/ID so a held entry is not re-counted.
    always @(posedge clk) begin
        held = rst_n && stall && !redirect_valid && !flush;
    end

    // Monitor: each fresh valid IF/ID entry must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ifid_valid && !held) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got pc %h with empty queue at %0t", ifid_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifid_pc", ifid_pc, e.pc);
                    chk("ifid_instr", ifid_instr, e.instr);
                    chk("ifid_pc_plus4", ifid_pc_plus4, e.pc + 32'd4);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(ifid_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, ifid_instr, 32'h0);
        chk({tag, "_pc"}, ifid_pc, 32'h0);
        chk({tag, "_pc4"}, ifid_pc_plus4, 32'h0);
    endtask

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        #3;
        chk_reset_vals("rst");
        #9;
        rst_n = 1'b1;

        // BOOT bubble, then sequential fetch from 0.
        step();
        chk("boot_valid", 32'(ifid_valid), 32'd0);
        chk("boot_addr", imem_addr, 32'h0);
        push(32'h0);
        push(32'h4);
        push(32'h8);
        step();
        step();
        chk("pre_stall_addr", imem_addr, 32'h8);

        // Stall three cycles at pc = 8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_ifid_pc", ifid_pc, 32'h4);
            chk("stall_ifid_instr", ifid_instr, 32'h1000_0001);
            chk("stall_valid", 32'(ifid_valid), 32'd1);
        end
        stall = 1'b0;
        step();

        // Redirect to 0x40 together with stall: redirect wins.
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        stall           = 1'b1;
        push(32'h40);
        step();
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", 32'(ifid_valid), 32'd0);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();

        // Misaligned redirect enters FAULT.
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        step();
        redirect_valid = 1'b0;
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_addr", imem_addr, 32'h42);
        chk("mis_valid", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fault_valid", 32'(ifid_valid), 32'd0);
            chk("fault_flag", 32'(fetch_fault), 32'd1);
            chk("fault_addr", imem_addr, 32'h42);
        end

        // Good redirect clears the fault.
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        push(32'h80);
        step();
        redirect_valid = 1'b0;
        chk("clr_fault", 32'(fetch_fault), 32'd0);
        chk("clr_valid", 32'(ifid_valid), 32'd0);
        chk("clr_addr", imem_addr, 32'h80);
        step();

        // Run off the end of memory.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFF4;
        push(32'hFF4);
        push(32'hFF8);
        push(32'hFFC);
        step();
        redirect_valid = 1'b0;
        chk("end_addr0", imem_addr, 32'hFF4);
        step();
        step();
        step();
        chk("end_last_pc", ifid_pc, 32'hFFC);
        chk("end_last_valid", 32'(ifid_valid), 32'd1);
        chk("end_fault", 32'(fetch_fault), 32'd1);
        chk("end_addr", imem_addr, 32'h1000);
        step();
        chk("end_fault2", 32'(fetch_fault), 32'd1);
        chk("end_valid2", 32'(ifid_valid), 32'd0);
        chk("end_addr2", imem_addr, 32'h1000);

        // Asynchronous reset mid-cycle while in FAULT.
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        #3;
        rst_n = 1'b1;
        push(32'h0);
        step();
        chk("reboot_valid", 32'(ifid_valid), 32'd0);
        chk("reboot_addr", imem_addr, 32'h0);
        step();

        // Flush alone: bubble, PC advances.
        flush = 1'b1;
        push(32'h8);
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(ifid_valid), 32'd0);
        chk("flush_addr", imem_addr, 32'h8);
        step();
        step();

        // Everything pushed must have been observed.
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction memory.
- Holds the program counter, drives the byte address into the memory, and accepts redirects from the branch/jump resolution stage.
- Registers the returned word, together with its PC and PC+4, into the IF/ID pipeline register.
- Handles stall, flush and misaligned/out-of-range fetch faults with a small state machine.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in words. Legal fetch range is 0 to IMEM_WORDS*4-4.
- NOP_INSTR, 32'h0000_0000, word placed in the IF/ID register when it holds a bubble.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hazard-unit hold; freezes the PC and the IF/ID register
- flush  input  1  converts the IF/ID contents into a bubble
- redirect_valid  input  1  branch/jump taken; load redirect_target
- redirect_target  input  32  new byte address
- imem_addr  output  32  byte address to instruction memory, combinational from the PC register
- imem_instr  input  32  word returned by instruction memory, combinational in the same cycle
- ifid_instr  output  32  registered instruction
- ifid_pc  output  32  registered PC of ifid_instr
- ifid_pc_plus4  output  32  registered ifid_pc + 4
- ifid_valid  output  1  IF/ID holds a real instruction
- fetch_fault  output  1  registered; high while in FAULT

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc = RESET_PC, state = BOOT.
  - ifid_instr = NOP_INSTR, ifid_pc = 0, ifid_pc_plus4 = 0, ifid_valid = 0, fetch_fault = 0.
  - Deassertion takes effect at the first rising edge with rst_n high.
- Address path: imem_addr = pc at all times. The memory read is combinational, so fetch-to-IF/ID latency is 1 cycle.
- A PC is "bad" if pc[1:0] != 0 or pc > IMEM_WORDS*4-4. The same check applies to redirect_target.
- States:
  - BOOT: lasts exactly 1 cycle after reset. IF/ID stays a bubble and the PC holds. Next state is RUN, or FAULT if RESET_PC is bad.
  - RUN: normal fetch.
  - FAULT: the PC holds, IF/ID is loaded with a bubble every cycle, and fetch_fault = 1. The only exit is redirect_valid with a good target, which goes to RUN. A redirect to a bad target stays in FAULT with pc = target.
- PC update in RUN, first match wins:
  1. redirect_valid: pc <= redirect_target. If the target is bad, go to FAULT.
  2. stall: pc holds.
  3. Otherwise pc <= pc + 4 (modulo 2^32). If pc + 4 is bad, go to FAULT.
- IF/ID update in RUN, first match wins:
  1. redirect_valid or flush: bubble, i.e. ifid_valid <= 0 and ifid_instr <= NOP_INSTR, with ifid_pc and ifid_pc_plus4 also loaded.
  2. stall: all IF/ID fields hold.
  3. Otherwise ifid_instr <= imem_instr, ifid_pc <= pc, ifid_pc_plus4 <= pc + 4, ifid_valid <= 1.
- Simultaneous events:
  - redirect + stall: redirect wins for both the PC and IF/ID.
  - flush + stall with no redirect: IF/ID becomes a bubble and the PC holds.
  - flush alone: IF/ID becomes a bubble and the PC advances.
- Wrap-around: pc + 4 from 32'hFFFF_FFFC is 0 arithmetically, but the range check already faults any address past the memory end. PC values never silently wrap into valid memory.
- Reset asserted mid-operation immediately forces all reset values, whatever the current state.

Test Plan:
- Reset with RESET_PC = 0, then run 4 cycles with no stall and memory word i = 32'h1000_0000 + i:
  - cycle 1 (BOOT): ifid_valid = 0.
  - cycles 2-4: ifid_pc = 0, 4, 8 with ifid_instr = 1000_0000, 1000_0001, 1000_0002; ifid_pc_plus4 = 4, 8, C.
- stall held 3 cycles at pc = 8: imem_addr stays 8 and the IF/ID fields stay frozen. On release the next ifid_pc = 8.
- redirect_valid with target 32'h40 and stall both high:
  - next cycle imem_addr = 40 and ifid_valid = 0;
  - the following cycle ifid_pc = 40 with the word at index 16.
- redirect to 32'h42 (misaligned):
  - next cycle fetch_fault = 1, and ifid_valid stays 0 for 5 cycles;
  - a redirect to 32'h80 clears the fault, and ifid_pc = 80 appears 1 cycle later.
- Sequential fetch reaching 32'hFFC with IMEM_WORDS = 1024: ifid_pc = FFC is captured valid, then fetch_fault = 1 and imem_addr holds 32'h1000.
- rst_n pulsed low asynchronously mid-cycle while in FAULT: all outputs return to reset values without waiting for a clock edge, and the BOOT bubble precedes the first fetch at RESET_PC.
